// File: rtl/lock_pkg.sv
// Shared definitions for the lock guard sequencer: state encoding, keypad codes
// and the seconds-counter width.
package lock_pkg;

    localparam int SEC_W = 8;

    localparam logic [3:0] KEY_HASH = 4'b1010;
    localparam logic [3:0] KEY_STAR = 4'b1011;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_OPENED  = 4'b0010,
        S_LOCKOUT = 4'b0100,
        S_ALARM   = 4'b1000
    } state_t;

    // Failure totals stick at 15 rather than wrapping back to a harmless value.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: pulses tick on the last count of each TICK_DIV period
// and restarts from zero whenever restart is asserted or run is low.
module sec_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_1,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would create order-
    // dependent simulation that does not match the synthesized hardware.
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            cnt_q <= '0;
        end else if (restart || !run || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // tick depends only on the register, so the FSM may use it to decide restart.
    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/lock_guard_ctrl.sv
// Security sequencer between keypad scanner and password decider: gates key
// presses, times the open window, enforces lockout and latches an alarm.
module lock_guard_ctrl
    import lock_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int OPEN_SEC    = 10,
    parameter int LOCKOUT_SEC = 30,
    parameter int MAX_TRIES   = 3,
    parameter int ALARM_TRIES = 6
) (
    input  logic             clk,
    input  logic             reset_1,
    input  logic             Valid_in,
    input  logic [3:0]       Code_in,
    input  logic [3:0]       count_Wrong,
    input  logic             OPEN,
    input  logic             clr_alarm,
    output logic             Valid_1,
    output logic [3:0]       Code_1,
    output logic             key_en,
    output logic             relock_req,
    output logic             LOCKOUT_LED,
    output logic             ALARM,
    output logic [SEC_W-1:0] secs_left,
    output logic [3:0]       tries_left
);

    if (TICK_DIV < 2 || OPEN_SEC < 1 || OPEN_SEC > 255 || LOCKOUT_SEC < 1 ||
        LOCKOUT_SEC > 255 || MAX_TRIES < 1 || MAX_TRIES > ALARM_TRIES ||
        ALARM_TRIES > 15) begin : g_param_err
        $error("lock_guard_ctrl: illegal parameter combination");
    end

    localparam logic [3:0]       MAX_TH   = 4'(MAX_TRIES);
    localparam logic [4:0]       ALARM_TH = 5'(ALARM_TRIES);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

    state_t           state_q, state_d;
    logic [SEC_W-1:0] secs_q, secs_d;
    logic [3:0]       try_q, try_d, total_q, total_d;
    logic             relock_q, relock_d;
    logic [3:0]       cw_q;
    logic             cw_vld_q;
    logic             open_q, open_take;
    logic             v_q, press_ok_q;
    logic [3:0]       code_q;
    logic             tick, run, restart;
    logic             fail_evt, open_rise, alarm_hit, lock_hit;

    // Only a +1 step of the decider counter is a failure; a clear to 0 is not.
    assign fail_evt  = cw_vld_q && (count_Wrong == cw_q + 4'd1);
    assign open_rise = OPEN && !open_q;
    assign alarm_hit = ({1'b0, total_q} + 5'd1) >= ALARM_TH;
    assign lock_hit  = (try_q + 4'd1) == MAX_TH;

    assign run     = (state_q == S_OPENED) || (state_q == S_LOCKOUT);
    assign restart = (state_d != state_q);

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_1 (reset_1),
        .restart (restart),
        .run     (run),
        .tick    (tick)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        try_d     = try_q;
        total_d   = total_q;
        relock_d  = 1'b0;
        open_take = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (fail_evt) begin
                    total_d = sat_inc4(total_q);
                    if (alarm_hit) begin
                        state_d = S_ALARM;
                    end else if (lock_hit) begin
                        state_d = S_LOCKOUT;
                        try_d   = '0;
                        secs_d  = SEC_W'(LOCKOUT_SEC);
                    end else begin
                        try_d = try_q + 4'd1;
                    end
                    // Leave the OPEN edge pending so it is acted on next cycle.
                    if (open_rise) open_take = 1'b0;
                end else if (open_rise) begin
                    state_d = S_OPENED;
                    try_d   = '0;
                    total_d = '0;
                    secs_d  = SEC_W'(OPEN_SEC);
                end else if (clr_alarm) begin
                    try_d   = '0;
                    total_d = '0;
                end
            end
            S_OPENED: begin
                if (!OPEN) begin
                    state_d = S_IDLE;
                    secs_d  = '0;
                end else if (tick) begin
                    if (secs_q == SEC_ONE) begin
                        relock_d = 1'b1;
                        state_d  = S_IDLE;
                        secs_d   = '0;
                    end else begin
                        secs_d = secs_q - SEC_ONE;
                    end
                end
            end
            S_LOCKOUT: begin
                if (fail_evt) total_d = sat_inc4(total_q);
                if (fail_evt && alarm_hit) begin
                    state_d = S_ALARM;
                    secs_d  = '0;
                end else if (clr_alarm) begin
                    state_d = S_IDLE;
                    try_d   = '0;
                    total_d = '0;
                    secs_d  = '0;
                end else if (tick) begin
                    if (secs_q == SEC_ONE) begin
                        state_d = S_IDLE;
                        secs_d  = '0;
                    end else begin
                        secs_d = secs_q - SEC_ONE;
                    end
                end
            end
            S_ALARM: begin
                if (clr_alarm) begin
                    state_d = S_IDLE;
                    try_d   = '0;
                    total_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                secs_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            state_q  <= S_IDLE;
            secs_q   <= '0;
            try_q    <= '0;
            total_q  <= '0;
            relock_q <= 1'b0;
            cw_q     <= '0;
            cw_vld_q <= 1'b0;
            open_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            secs_q   <= secs_d;
            try_q    <= try_d;
            total_q  <= total_d;
            relock_q <= relock_d;
            cw_q     <= count_Wrong;
            cw_vld_q <= 1'b1;
            if (open_take) open_q <= OPEN;
        end
    end

    // A press keeps the acceptance decided at its rising edge until released.
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            v_q        <= 1'b0;
            press_ok_q <= 1'b0;
            code_q     <= '0;
        end else begin
            v_q    <= Valid_in;
            code_q <= Code_in;
            if (Valid_in && !v_q) press_ok_q <= key_en;
        end
    end

    assign key_en      = (state_q == S_IDLE) || (state_q == S_OPENED);
    assign Valid_1     = v_q && press_ok_q;
    assign Code_1      = code_q;
    assign relock_req  = relock_q;
    assign LOCKOUT_LED = (state_q == S_LOCKOUT);
    assign ALARM       = (state_q == S_ALARM);
    assign secs_left   = secs_q;
    assign tries_left  = MAX_TH - try_q;

endmodule
